// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: line-granular main-memory responder behind the cache
// miss/eviction interface. It serves one request at a time, with a fixed
// access latency, and answers with a single-cycle response pulse.
//
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   iReadAddr/Req      instruction-cache line read request (level, held)
//   iReadData/LineValid  returned line and its one-cycle valid pulse
//   dReadAddr/Req      data-cache line read request (level, held)
//   dReadData/LineValid  returned line and its one-cycle valid pulse
//   dWriteAddr/Line/Req  data-cache eviction (level, held)
//   dWriteAck          one-cycle pulse once the line is committed
//   busy               high whenever the controller is not idle
//
// The array starts zero-filled. Reset never touches the array.
module mem_line_ctrl #(
  parameter int unsigned ARCH_BITS = 32,
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned IDX_BITS  = 10,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ARCH_BITS-1:0] iReadAddr,
  input  logic                 iReadReq,
  output logic [LINE_BITS-1:0] iReadData,
  output logic                 iReadLineValid,
  input  logic [ARCH_BITS-1:0] dReadAddr,
  input  logic                 dReadReq,
  output logic [LINE_BITS-1:0] dReadData,
  output logic                 dReadLineValid,
  input  logic [ARCH_BITS-1:0] dWriteAddr,
  input  logic [LINE_BITS-1:0] dWriteLine,
  input  logic                 dWriteReq,
  output logic                 dWriteAck,
  output logic                 busy
);

  localparam int unsigned OFF   = $clog2(LINE_BITS / 8);
  localparam int unsigned DEPTH = 2 ** IDX_BITS;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;
  typedef enum logic [1:0] {OP_IREAD, OP_DREAD, OP_WRITE} op_e;

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rr_ptr_q, rr_ptr_d;
  logic [IDX_BITS-1:0]    idx_q, idx_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic [LINE_BITS-1:0]   i_data_q, i_data_d;
  logic [LINE_BITS-1:0]   d_data_q, d_data_d;
  logic                   i_valid_q, i_valid_d;
  logic                   d_valid_q, d_valid_d;
  logic                   w_ack_q, w_ack_d;
  logic                   busy_q, busy_d;
  logic                   mem_we;

  logic [LINE_BITS-1:0]   mem_q [DEPTH];

  // Offset bits and bits above the index are deliberately ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iReadAddr, dReadAddr, dWriteAddr};

  // Power-up content of the backing store.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_q[IDX_BITS'(i)] = '0;
    end
  end

  // Grant arbitration, latency countdown and response generation.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    i_data_d  = i_data_q;
    d_data_d  = d_data_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    w_ack_d   = 1'b0;
    mem_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dWriteReq) begin
          // Evictions win so a paired miss read sees the written line.
          op_d    = OP_WRITE;
          idx_d   = dWriteAddr[OFF +: IDX_BITS];
          wdata_d = dWriteLine;
          state_d = ST_BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end else if (dReadReq && (!iReadReq || !rr_ptr_q)) begin
          op_d     = OP_DREAD;
          idx_d    = dReadAddr[OFF +: IDX_BITS];
          rr_ptr_d = 1'b1;
          state_d  = ST_BUSY;
          cnt_d    = CNT_W'(LATENCY - 1);
        end else if (iReadReq) begin
          op_d     = OP_IREAD;
          idx_d    = iReadAddr[OFF +: IDX_BITS];
          rr_ptr_d = 1'b0;
          state_d  = ST_BUSY;
          cnt_d    = CNT_W'(LATENCY - 1);
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          // The commit and the read both land on the edge that enters RESP.
          state_d = ST_RESP;
          case (op_q)
            OP_WRITE: begin
              mem_we  = 1'b1;
              w_ack_d = 1'b1;
            end
            OP_DREAD: begin
              d_data_d  = mem_q[idx_q];
              d_valid_d = 1'b1;
            end
            default: begin
              i_data_d  = mem_q[idx_q];
              i_valid_d = 1'b1;
            end
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        // One forced idle cycle lets the requester drop its level request.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_IREAD;
      cnt_q     <= '0;
      rr_ptr_q  <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      i_data_q  <= '0;
      d_data_q  <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      w_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      i_data_q  <= i_data_d;
      d_data_q  <= d_data_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      w_ack_q   <= w_ack_d;
      busy_q    <= busy_d;
    end
  end

  // Backing store write port; no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign iReadData      = i_data_q;
  assign iReadLineValid = i_valid_q;
  assign dReadData      = d_data_q;
  assign dReadLineValid = d_valid_q;
  assign dWriteAck      = w_ack_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
module tb_mem_line_ctrl;

  localparam int unsigned L  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;

  localparam logic [1:0] K_I = 2'd0;
  localparam logic [1:0] K_D = 2'd1;
  localparam logic [1:0] K_W = 2'd2;

  localparam logic [LW-1:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [LW-1:0] D2 = 128'hA5A5A5A5_11112222_33334444_5A5A5A5A;
  localparam logic [LW-1:0] D3 = 128'h33333333_33333333_33333333_33333333;
  localparam logic [LW-1:0] D4 = 128'h44444444_44444444_44444444_44444444;
  localparam logic [LW-1:0] D5 = 128'h55555555_0000AAAA_55555555_0000AAAA;
  localparam logic [LW-1:0] D6 = 128'h66666666_FFFFFFFF_66666666_FFFFFFFF;

  logic          clk;
  logic          rst;
  logic [AW-1:0] iReadAddr;
  logic          iReadReq;
  logic [LW-1:0] iReadData;
  logic          iReadLineValid;
  logic [AW-1:0] dReadAddr;
  logic          dReadReq;
  logic [LW-1:0] dReadData;
  logic          dReadLineValid;
  logic [AW-1:0] dWriteAddr;
  logic [LW-1:0] dWriteLine;
  logic          dWriteReq;
  logic          dWriteAck;
  logic          busy;

  mem_line_ctrl #(
    .ARCH_BITS(AW),
    .LINE_BITS(LW),
    .IDX_BITS (10),
    .LATENCY  (L)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .iReadAddr     (iReadAddr),
    .iReadReq      (iReadReq),
    .iReadData     (iReadData),
    .iReadLineValid(iReadLineValid),
    .dReadAddr     (dReadAddr),
    .dReadReq      (dReadReq),
    .dReadData     (dReadData),
    .dReadLineValid(dReadLineValid),
    .dWriteAddr    (dWriteAddr),
    .dWriteLine    (dWriteLine),
    .dWriteReq     (dWriteReq),
    .dWriteAck     (dWriteAck),
    .busy          (busy)
  );

  typedef struct {
    logic [1:0]    kind;
    logic [LW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc;
  int          n_checks;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [1:0] kind, input logic [LW-1:0] data, input int unsigned at);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Waits for the pulse of the given kind; an expired budget is a failure.
  task automatic wait_pulse(input logic [1:0] kind, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      case (kind)
        K_I:     seen = iReadLineValid;
        K_D:     seen = dReadLineValid;
        default: seen = dWriteAck;
      endcase
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: no pulse of kind %0d within %0d cycles", kind, budget);
    end
  endtask

  // Single request from an idle controller: grant on the next edge.
  task automatic do_op(input logic [1:0] kind, input logic [AW-1:0] addr, input logic [LW-1:0] data);
    @(negedge clk);
    push_exp(kind, (kind == K_W) ? '0 : data, cyc + 1 + L);
    case (kind)
      K_I: begin iReadAddr = addr; iReadReq = 1'b1; end
      K_D: begin dReadAddr = addr; dReadReq = 1'b1; end
      default: begin dWriteAddr = addr; dWriteLine = data; dWriteReq = 1'b1; end
    endcase
    wait_pulse(kind, 20);
    iReadReq  = 1'b0;
    dReadReq  = 1'b0;
    dWriteReq = 1'b0;
  endtask

  // Scoreboard monitor: every response pulse must match the queue head.
  always @(negedge clk) begin : monitor
    logic [1:0]    k;
    logic [LW-1:0] d;
    exp_t          e;
    if (!rst && (iReadLineValid || dReadLineValid || dWriteAck)) begin
      check("one_pulse_per_cycle", LW'(iReadLineValid) + LW'(dReadLineValid) + LW'(dWriteAck), 1);
      k = dWriteAck ? K_W : (dReadLineValid ? K_D : K_I);
      d = dReadLineValid ? dReadData : iReadData;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none required", k, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", LW'(k), LW'(e.kind));
        check("pulse_cycle", LW'(cyc), LW'(e.cyc));
        if (e.kind != K_W) check("pulse_data", d, e.data);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned c0;
    int          nb;
    int          seen;
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b1;
    iReadAddr  = '0;
    iReadReq   = 1'b0;
    dReadAddr  = '0;
    dReadReq   = 1'b0;
    dWriteAddr = '0;
    dWriteLine = '0;
    dWriteReq  = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_iValid", LW'(iReadLineValid), 0);
    check("rst_dValid", LW'(dReadLineValid), 0);
    check("rst_ack",    LW'(dWriteAck), 0);
    check("rst_busy",   LW'(busy), 0);
    check("rst_iData",  iReadData, 0);
    check("rst_dData",  dReadData, 0);
    rst = 1'b0;

    // Instruction read of index 1 from a zero-filled array; busy for L+1 cycles.
    @(negedge clk);
    @(negedge clk);
    c0 = cyc;
    push_exp(K_I, '0, c0 + 1 + L);
    iReadAddr = 32'h0000_0010;
    iReadReq  = 1'b1;
    nb = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (iReadLineValid) iReadReq = 1'b0;
    end
    iReadReq = 1'b0;
    check("busy_cycles", LW'(nb), LW'(L + 1));

    // Eviction and miss read to the same line together: write first.
    @(negedge clk);
    c0 = cyc;
    push_exp(K_W, '0, c0 + 1 + L);
    push_exp(K_D, D1, c0 + 1 + L + L + 2);
    dWriteAddr = 32'h0000_0020;
    dWriteLine = D1;
    dWriteReq  = 1'b1;
    dReadAddr  = 32'h0000_0020;
    dReadReq   = 1'b1;
    wait_pulse(K_W, 20);
    dWriteReq = 1'b0;
    wait_pulse(K_D, 20);
    dReadReq = 1'b0;

    // Address wrap: 0x4030 aliases 0x30 (index 3).
    do_op(K_W, 32'h0000_0030, D2);
    do_op(K_D, 32'h0000_4030, D2);
    do_op(K_I, 32'h0000_0030, D2);
    @(negedge clk);
    check("dData_hold", dReadData, D2);

    // Both readers held high: grants alternate D, I, D, I.
    do_op(K_W, 32'h0000_0060, D3);
    do_op(K_W, 32'h0000_0070, D4);
    @(negedge clk);
    c0 = cyc;
    push_exp(K_D, D3, c0 + 1 + L);
    push_exp(K_I, D4, c0 + 1 + L + (L + 2));
    push_exp(K_D, D3, c0 + 1 + L + 2 * (L + 2));
    push_exp(K_I, D4, c0 + 1 + L + 3 * (L + 2));
    dReadAddr = 32'h0000_0060;
    iReadAddr = 32'h0000_0070;
    dReadReq  = 1'b1;
    iReadReq  = 1'b1;
    seen = 0;
    for (int i = 0; i < 60 && seen < 4; i++) begin
      @(negedge clk);
      if (iReadLineValid || dReadLineValid) seen++;
    end
    dReadReq = 1'b0;
    iReadReq = 1'b0;
    check("rr_pulse_count", LW'(seen), 4);

    // Async reset in the middle of a write to index 5 aborts it.
    do_op(K_W, 32'h0000_0050, D5);
    @(negedge clk);
    dWriteAddr = 32'h0000_0050;
    dWriteLine = D6;
    dWriteReq  = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    dWriteReq = 1'b0;
    #1;
    check("abort_busy",  LW'(busy), 0);
    check("abort_iData", iReadData, 0);
    check("abort_dData", dReadData, 0);
    check("abort_ack",   LW'(dWriteAck), 0);
    @(negedge clk);
    rst = 1'b0;
    do_op(K_D, 32'h0000_0050, D5);
    do_op(K_I, 32'h0000_0020, D1);

    repeat (10) @(negedge clk);
    check("scoreboard_empty", LW'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
